// File: rtl/slc3_key_conditioner.sv
// slc3_key_conditioner: N-channel active-low key synchroniser, debouncer and press/release pulse generator.
// Defining KEY_AUTOREPEAT_EN adds per-channel auto-repeat of press pulses while a key is held.

module slc3_key_chan #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_ni,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
      $error("slc3_key_chan: illegal parameter value");
   end

   logic [1:0]    sync_q;
   logic          synced;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, press_q, release_q;
   logic          press_d, release_d;

   assign synced = sync_q[1];

   // Any sample that agrees with the accepted state restarts the count.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (synced != stable_q) begin
         if (cnt_q == CNT_LAST) stable_d = synced;
         else                   cnt_d    = cnt_q + 1'b1;
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          rep_q, rep_d, rep_fire;

   // rcnt counts edges since the last press pulse; rep_q marks that the first repeat is done.
   always_comb begin
      rcnt_d   = '0;
      rep_d    = 1'b0;
      rep_fire = 1'b0;
      if (stable_q && level_q) begin
         rep_fire = rep_q ? (rcnt_q == PER_LAST) : (rcnt_q == DLY_LAST);
         if (rep_fire) begin
            rep_d = 1'b1;
         end else begin
            rcnt_d = rcnt_q + 1'b1;
            rep_d  = rep_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rcnt_q <= '0;
         rep_q  <= 1'b0;
      end else begin
         rcnt_q <= rcnt_d;
         rep_q  <= rep_d;
      end
   end

   assign press_d = (stable_q & ~level_q) | rep_fire;
`else
   assign press_d = stable_q & ~level_q;
`endif

   assign release_d = ~stable_q & level_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q    <= '0;
         stable_q  <= 1'b0;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], ~key_ni};
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         level_q   <= stable_q;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

module slc3_key_conditioner #(
   parameter int N_CH            = 3,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [N_CH-1:0] key_n,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_press,
   output logic [N_CH-1:0] btn_release,
   output logic            any_press
);

   if (N_CH < 1) begin : g_nch_err
      $error("slc3_key_conditioner: N_CH must be at least 1");
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      slc3_key_chan #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_chan (
         .clk_i    (Clk),
         .rst_ni   (Reset),
         .key_ni   (key_n[c]),
         .level_o  (btn_level[c]),
         .press_o  (btn_press[c]),
         .release_o(btn_release[c])
      );
   end

   assign any_press = |btn_press;

endmodule

// File: doc/slc3_key_conditioner.md
# slc3_key_conditioner

Parametrised, N-channel conditioner for the active-low board push-buttons that drive the SLC-3 top level (Run, Continue, and spare keys). Each channel synchronises its raw key to `Clk`, debounces it with a per-channel counter, and produces a clean level plus single-cycle press and release pulses. It sits between the board pins and `slc3`, replacing hand-driven Run/Continue levels with glitch-free, edge-qualified strobes. An optional auto-repeat mode re-issues press pulses while a key is held.

## Interface
- `N_CH`, default 3: number of key channels; must be at least 1.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a change (1 ms at 50 MHz); must be at least 2.
- `REPEAT_DELAY`, default 25000000: cycles from press pulse to first repeat pulse; used only with auto-repeat.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent repeat pulses; used only with auto-repeat.
- `Clk` in 1: system clock, 50 MHz.
- `Reset` in 1: asynchronous, active-low reset.
- `key_n` in N_CH: raw board keys, active-low (0 = pressed), asynchronous to `Clk`.
- `btn_level` out N_CH: debounced key state, active-high (1 = pressed).
- `btn_press` out N_CH: one-cycle pulse on accepted press (and on repeats when enabled).
- `btn_release` out N_CH: one-cycle pulse on accepted release.
- `any_press` out 1: OR of all `btn_press` bits.

## Operation
- Channels are fully independent; every per-channel register is replicated `N_CH` times.
- Synchroniser: two flops per channel on `~key_n`; both reset to 0 (released).
- Debounce: `stable` flop plus counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - Synchroniser output equals `stable`: counter cleared to 0.
  - Mismatch and counter below `DEBOUNCE_CYCLES-1`: counter increments.
  - Mismatch and counter at `DEBOUNCE_CYCLES-1`: `stable` takes the synchronised value and the counter clears. `btn_press` is asserted if the new value is 1; `btn_release` is asserted if it is 0.
  - Any single-cycle agreement during counting restarts the count, so bounces shorter than `DEBOUNCE_CYCLES` are rejected.
- `btn_level`, `btn_press` and `btn_release` are registered. `any_press` is a combinational OR of the registered `btn_press`.
- `btn_press` and `btn_release` never assert together on one channel.

## Timing
- Reset values (asynchronous, while `Reset`=0): all synchroniser flops, `stable`, counters and pulse registers are 0. `btn_level`=0, `btn_press`=0, `btn_release`=0, `any_press`=0.
- Latency: `key_n` changes before edge 0 and stays steady. `btn_level` changes and the pulse asserts after edge `2+DEBOUNCE_CYCLES`. The pulse lasts exactly one cycle.
- Key held low across reset deassertion: treated as a new press. The press pulse fires `2+DEBOUNCE_CYCLES` edges after the first post-reset edge.
- Reset asserted mid-count or mid-pulse: the count is abandoned and the pulse is cut immediately. No pulse is emitted for a change still pending when reset was asserted.
- Simultaneous acceptances on several channels: each channel pulses in the same cycle, and `any_press` is 1 for that cycle.

## Configuration
- Macro `KEY_AUTOREPEAT_EN`.
- Defined: each channel has a repeat counter, cleared on every press pulse and on release.
  - While `btn_level`=1, the channel re-pulses `btn_press` `REPEAT_DELAY` cycles after the initial press pulse.
  - It then re-pulses every `REPEAT_PERIOD` cycles.
  - An accepted release stops repeats at once; no repeat pulse occurs in the release cycle.
- Undefined: exactly one `btn_press` per accepted press. The repeat parameters are accepted but ignored, and no repeat logic is synthesised.

## Test plan
Bench settings: `N_CH`=3, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Reset check: drive `Reset`=0 with `key_n`=3'b000 -> all outputs 0 during reset. After release, `btn_level` goes to 3'b111 and `btn_press` pulses 3'b111 once, 6 edges after the first post-reset edge.
- Clean press and release on ch0: `key_n[0]` 1->0 held 20 cycles -> `btn_level[0]` rises and `btn_press[0]` pulses after edge 6. On return to 1 -> `btn_release[0]` pulses after edge 6.
- Bounce rejection on ch1: toggle `key_n[1]` low 3 cycles / high 1 cycle, repeated 5 times, then low steady -> no pulse during bouncing. Exactly one `btn_press[1]` 6 edges after the final steady low.
- Simultaneous channels: ch0 and ch2 pressed on the same cycle -> `btn_press`=3'b101 and `any_press`=1 for one cycle.
- Mid-count reset: press ch1, assert `Reset` after 3 edges -> no pulse. After deassertion with the key still held -> the press is accepted 6 edges later.
- With `KEY_AUTOREPEAT_EN`: hold ch0 for 30 cycles -> press pulses at cycle p, then p+10, p+13, p+16… Release -> pulses stop and `btn_release[0]` fires once.
